dither_stream_ctrl: RTL and testbench

- Frame-level sequencer for the RGB 8:8:8 to 4:4:4 round-to-nearest quantizer used ahead of the 12-bit VGA output.
- Accepts a 24-bit pixel stream over valid/ready, quantizes each channel, and emits a 12-bit stream with frame and line markers.
- Latches the dither-enable configuration only at frame start, so the mode never changes mid-frame.
- Tracks x/y position and reports busy and frame-done status to the system controller.

---
 rtl/dither_stream_ctrl.sv | 155 +++++++++++++++
 tb/tb_dither_stream_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_stream_ctrl.sv
// Frame sequencer for the RGB 8:8:8 -> 4:4:4 quantizer feeding the 12-bit VGA path.
// Takes 24-bit pixels over valid/ready, registers one quantized 12-bit pixel with
// sof/eol/eof markers, tracks x/y, and latches the dither mode once per frame.
// Handshake: a transfer happens on any cycle where valid && ready are both high;
// valid never depends on ready, and a presented output holds until it is taken.
module dither_stream_ctrl #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dither_en,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [23:0] s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [11:0] m_data,
    output logic        m_sof,
    output logic        m_eol,
    output logic        m_eof,
    input  logic        m_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            en_lat;
    logic            in_xfer;
    logic            out_xfer;
    logic            first_px;
    logic            eol_px;
    logic            last_px;

    // Round-to-nearest on the upper nibble, saturating so 0xF never wraps to 0x0.
    function automatic logic [3:0] quant(input logic [7:0] c, input logic en);
        if (en && (c[3:0] >= 4'd8) && (c[7:4] < 4'd15))
            return c[7:4] + 4'd1;
        else
            return c[7:4];
    endfunction

    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;
    assign first_px = (x == '0) && (y == '0);
    assign eol_px   = (x == X_LAST);
    assign last_px  = eol_px && (y == Y_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: abort wins over everything, start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = ACTIVE;
                ACTIVE:  if (in_xfer && last_px) state_nxt = FLUSH;
                FLUSH:   if (m_ready) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State-decoded outputs; input is accepted only when the output slot frees up.
    always_comb begin
        s_ready    = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            ACTIVE: begin
                s_ready = !m_valid || m_ready;
                busy    = 1'b1;
            end
            FLUSH:   busy = 1'b1;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    // Position counters and the per-frame dither mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            en_lat <= 1'b0;
        end else if (abort) begin
            x <= '0;
            y <= '0;
        end else if (state == IDLE && start) begin
            en_lat <= dither_en;
            x      <= '0;
            y      <= '0;
        end else if (in_xfer) begin
            if (eol_px) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Single-stage output register; a new pixel replaces a departing one without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (abort) begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (in_xfer) begin
            m_valid <= 1'b1;
            m_data  <= {quant(s_data[23:16], en_lat),
                        quant(s_data[15:8],  en_lat),
                        quant(s_data[7:0],   en_lat)};
            m_sof   <= first_px;
            m_eol   <= eol_px;
            m_eof   <= last_px;
        end else if (out_xfer) begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dither_stream_ctrl.sv
// Bench for dither_stream_ctrl with a small 4x2 frame. A frame-level reference
// model predicts every output pixel, marker, busy/frame_done and s_ready.
module tb_dither_stream_ctrl;

    localparam int H = 4;
    localparam int V = 2;
    localparam int N = H * V;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        dither_en;
    logic        abort;
    logic        s_valid;
    logic [23:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [11:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic        m_ready;
    logic        busy;
    logic        frame_done;

    dither_stream_ctrl #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dither_en(dither_en),
        .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
        .m_eof(m_eof), .m_ready(m_ready), .busy(busy), .frame_done(frame_done)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and counters.
    int errs   = 0;
    int checks = 0;
    logic [14:0] exp_q[$];

    // Reference model state: 0 idle, 1 in frame (busy), 2 frame just finished.
    int   mst = 0;
    int   pix_cnt = 0;
    bit   en_m = 0;
    bit   hold_prev = 0;
    logic [14:0] hold_val;
    int   cyc = 0;
    int   last_acc_cyc = 0;

    // Stimulus knobs.
    int   pv = 100;
    int   pr = 100;
    bit   const_on = 0;
    logic [23:0] const_pix = '0;
    logic [11:0] const_exp = '0;
    bit   dith_rand = 0;
    bit   bp_arm = 0;
    int   hold = 0;
    int   abort_at = -1;
    bit   cont_chk = 0;
    bit   req_start = 0;
    bit   req_en = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] qz(input logic [7:0] c, input bit en);
        int v;
        v = en ? (int'(c) + 8) / 16 : int'(c) / 16;
        if (v > 15) v = 15;
        return 4'(v);
    endfunction

    // Drive inputs shortly after the rising edge.
    task automatic drive();
        @(posedge clk);
        #1;
        s_valid = ($urandom_range(0, 99) < pv);
        s_data  = const_on ? const_pix : 24'($urandom);
        if (bp_arm && m_valid) begin
            bp_arm = 0;
            hold   = 5;
        end
        if (hold > 0) begin
            m_ready = 1'b0;
            hold--;
        end else begin
            m_ready = ($urandom_range(0, 99) < pr);
        end
        if (req_start)      dither_en = req_en;
        else if (dith_rand) dither_en = 1'($urandom_range(0, 1));
        start = req_start || (mst != 0 && $urandom_range(0, 99) < 4);
        abort = (abort_at >= 0 && mst == 1 && pix_cnt == abort_at);
        if (abort) abort_at = -1;
    endtask

    // Compare on the falling edge, then advance the model across the next rising edge.
    task automatic evaluate();
        logic [14:0] obs;
        logic [14:0] e;
        logic exp_sr;
        logic acc;
        logic popped_eof;
        int px;
        int py;
        @(negedge clk);
        cyc++;
        obs = {m_sof, m_eol, m_eof, m_data};
        check("busy", busy, (mst == 1));
        check("frame_done", frame_done, (mst == 2));
        check("m_valid", m_valid, (exp_q.size() != 0));
        if (hold_prev) check("hold_stable", obs, hold_val);
        exp_sr = (mst == 1) && (pix_cnt < N) && (exp_q.size() == 0 || m_ready);
        check("s_ready", s_ready, exp_sr);
        if (frame_done && cont_chk) check("done_latency", cyc - last_acc_cyc, 2);
        popped_eof = 1'b0;
        if (m_valid && m_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pixel", obs, e);
            if (const_on) check("const_pixel", m_data, const_exp);
            popped_eof = e[12];
        end
        hold_prev = m_valid && !m_ready;
        hold_val  = obs;
        acc = s_valid && exp_sr;
        if (abort) begin
            mst = 0;
            exp_q.delete();
            pix_cnt = 0;
            hold_prev = 0;
        end else begin
            case (mst)
                0: if (start) begin
                    mst = 1;
                    en_m = dither_en;
                    pix_cnt = 0;
                end
                1: begin
                    if (popped_eof) mst = 2;
                    if (acc) begin
                        px = pix_cnt % H;
                        py = pix_cnt / H;
                        exp_q.push_back({(px == 0 && py == 0), (px == H - 1), (pix_cnt == N - 1),
                                         qz(s_data[23:16], en_m), qz(s_data[15:8], en_m),
                                         qz(s_data[7:0], en_m)});
                        pix_cnt++;
                        last_acc_cyc = cyc;
                    end
                end
                default: mst = 0;
            endcase
        end
    endtask

    task automatic cycle();
        drive();
        evaluate();
    endtask

    task automatic run_frame(input bit en);
        int b;
        req_start = 1;
        req_en = en;
        cycle();
        req_start = 0;
        b = 0;
        while (mst != 0 && b < 300) begin
            cycle();
            b++;
        end
        check("frame_timeout", (b < 300), 1);
        repeat (2) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_markers"}, {m_sof, m_eol, m_eof}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_s_ready"}, s_ready, 0);
    endtask

    initial begin
        rst_n = 0; start = 0; dither_en = 0; abort = 0;
        s_valid = 0; s_data = '0; m_ready = 0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Rounding with dither on, continuous stream, frame_done latency.
        const_on = 1; const_pix = 24'h18F817; const_exp = 12'h2F1;
        pv = 100; pr = 100; cont_chk = 1;
        run_frame(1);
        // Same pixel with dither off.
        const_exp = 12'h1F1;
        run_frame(0);
        cont_chk = 0;

        // Mode latch: dither_en wanders mid-frame, result must stay rounded.
        const_pix = 24'h888888; const_exp = 12'h999;
        dith_rand = 1; pv = 70; pr = 70;
        run_frame(1);
        const_on = 0;

        // Backpressure after the first output.
        bp_arm = 1; pv = 100; pr = 100;
        run_frame(1'($urandom_range(0, 1)));

        // Randomized frames.
        repeat (12) begin
            pv = $urandom_range(30, 100);
            pr = $urandom_range(30, 100);
            run_frame(1'($urandom_range(0, 1)));
        end

        // Abort while pixel 3 is arriving, then a normal frame.
        pv = 80; pr = 80; abort_at = 3;
        run_frame(1);
        check("abort_taken", abort_at, -1);
        run_frame(0);

        // Asynchronous reset mid-frame, then a full frame.
        pv = 100; pr = 100;
        req_start = 1; req_en = 1;
        cycle();
        req_start = 0;
        repeat (4) cycle();
        @(posedge clk);
        #1;
        start = 0; abort = 0;
        rst_n = 0;
        #1;
        check_all_zero("mid_reset");
        mst = 0; exp_q.delete(); pix_cnt = 0; hold_prev = 0;
        @(posedge clk);
        #1 rst_n = 1;
        evaluate();
        run_frame(1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
